// File: rtl/display_timing_gen.sv
// Raster timing generator: signed screen coordinates plus sync/DE/line/frame strobes.
// Latency: every output is registered and describes the position presented in the same cycle.
// Backpressure: i_en=0 freezes the raster and holds all outputs; o_line/o_frame are forced low.
//
// Ports:
//   clk_pix      pixel clock
//   rst_pix_n    synchronous active-low reset
//   i_en         advance enable
//   o_x, o_y     signed position; negative in blanking, 0..RES-1 in the active area
//   o_hsync      horizontal sync (SYNC_POL when active)
//   o_vsync      vertical sync (SYNC_POL when active)
//   o_de         data enable, high in the active area
//   o_line       one-cycle strobe at the first pixel of every line
//   o_frame      one-cycle strobe at the first pixel of every frame
//   o_frame_cnt  completed-frame count, wraps at 2^16
module display_timing_gen #(
  parameter int CORDW    = 16,
  parameter int H_RES    = 1280,
  parameter int V_RES    = 720,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    i_en,
  output logic signed [CORDW-1:0] o_x,
  output logic signed [CORDW-1:0] o_y,
  output logic                    o_hsync,
  output logic                    o_vsync,
  output logic                    o_de,
  output logic                    o_line,
  output logic                    o_frame,
  output logic [15:0]             o_frame_cnt
);

  // Blanking occupies the negative coordinate range so the active area starts at 0.
  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] H_LAST = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] V_LAST = CORDW'(V_RES - 1);
  localparam logic signed [CORDW-1:0] HS_BEG = CORDW'(-(H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(-(H_BP + 1));
  localparam logic signed [CORDW-1:0] VS_BEG = CORDW'(-(V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(-(V_BP + 1));
  localparam logic signed [CORDW-1:0] ZERO   = '0;
  localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

  typedef enum logic {S_START, S_RUN} state_t;

  state_t state_q, state_nxt;

  logic signed [CORDW-1:0] x_nxt, y_nxt;
  logic [15:0]             frame_cnt_nxt;
  logic                    hsync_nxt, vsync_nxt, de_nxt, line_nxt, frame_nxt;

  // State register
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) state_q <= S_START;
    else            state_q <= state_nxt;
  end

  // Next-state logic: the first enabled cycle after reset only announces the start position.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_START: if (i_en) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_START;
    endcase
  end

  // Output logic: next position and the decodes that describe it.
  always_comb begin
    x_nxt         = o_x;
    y_nxt         = o_y;
    frame_cnt_nxt = o_frame_cnt;
    line_nxt      = 1'b0;
    frame_nxt     = 1'b0;
    if (i_en) begin
      case (state_q)
        S_START: begin
          // Position already sits at (H_STA, V_STA) from reset; just strobe.
          line_nxt  = 1'b1;
          frame_nxt = 1'b1;
        end
        default: begin
          if (o_x == H_LAST) begin
            x_nxt    = H_STA;
            line_nxt = 1'b1;
            if (o_y == V_LAST) begin
              y_nxt         = V_STA;
              frame_nxt     = 1'b1;
              frame_cnt_nxt = o_frame_cnt + 16'd1;
            end else begin
              y_nxt = o_y + ONE;
            end
          end else begin
            x_nxt = o_x + ONE;
          end
        end
      endcase
    end
    // Decoding the next position keeps syncs/DE aligned with the coordinates they belong to.
    hsync_nxt = ((x_nxt >= HS_BEG) && (x_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt = ((y_nxt >= VS_BEG) && (y_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    de_nxt    = (x_nxt >= ZERO) && (y_nxt >= ZERO);
  end

  // Output registers
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      o_x         <= H_STA;
      o_y         <= V_STA;
      o_hsync     <= ~SYNC_POL;
      o_vsync     <= ~SYNC_POL;
      o_de        <= 1'b0;
      o_line      <= 1'b0;
      o_frame     <= 1'b0;
      o_frame_cnt <= 16'd0;
    end else begin
      o_x         <= x_nxt;
      o_y         <= y_nxt;
      o_hsync     <= hsync_nxt;
      o_vsync     <= vsync_nxt;
      o_de        <= de_nxt;
      o_line      <= line_nxt;
      o_frame     <= frame_nxt;
      o_frame_cnt <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: a reduced raster (inverted sync polarity) plus the 720p default.
// Both instances share clock, reset and enable and are compared every cycle against a raster model.
// The model tracks only "enabled advances since frame start" and derives every output arithmetically.
module tb_display_timing_gen;

  // Reduced raster: 21 pixels/line, 13 lines/frame, active-low syncs.
  localparam int S_HRES = 12, S_VRES = 6;
  localparam int S_HFP = 3, S_HSYNC = 2, S_HBP = 4;
  localparam int S_VFP = 2, S_VSYNC = 2, S_VBP = 3;

  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b0;
  logic i_en = 1'b0;

  always #5 clk_pix = ~clk_pix;

  logic signed [15:0] s_x, s_y, f_x, f_y;
  logic s_hs, s_vs, s_de, s_ln, s_fr, f_hs, f_vs, f_de, f_ln, f_fr;
  logic [15:0] s_fc, f_fc;

  display_timing_gen #(
    .CORDW(16), .H_RES(S_HRES), .V_RES(S_VRES),
    .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP), .SYNC_POL(1'b0)
  ) dut_small (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .i_en(i_en),
    .o_x(s_x), .o_y(s_y), .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de),
    .o_line(s_ln), .o_frame(s_fr), .o_frame_cnt(s_fc)
  );

  display_timing_gen dut_full (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .i_en(i_en),
    .o_x(f_x), .o_y(f_y), .o_hsync(f_hs), .o_vsync(f_vs), .o_de(f_de),
    .o_line(f_ln), .o_frame(f_fr), .o_frame_cnt(f_fc)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-instance raster geometry (index 0 = reduced, 1 = 720p).
  int hres[2], vres[2], hfp[2], hsw[2], hbp[2], vfp[2], vsw[2], vbp[2], pol[2];
  int ht[2], vt[2], tot[2];

  // Model state: started flag, advance index within the frame, frame count, strobes.
  bit m_st[2], m_ln[2], m_fr[2];
  int m_k[2], m_fc[2];

  task automatic model_step(input bit r, input bit e);
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        m_st[i] = 0; m_k[i] = 0; m_fc[i] = 0; m_ln[i] = 0; m_fr[i] = 0;
      end else if (e) begin
        if (!m_st[i]) begin
          m_st[i] = 1; m_k[i] = 0; m_ln[i] = 1; m_fr[i] = 1;
        end else begin
          m_k[i]++;
          if (m_k[i] == tot[i]) begin
            m_k[i]  = 0;
            m_fc[i] = (m_fc[i] + 1) % 65536;
          end
          m_ln[i] = (m_k[i] % ht[i]) == 0;
          m_fr[i] = (m_k[i] == 0);
        end
      end else begin
        m_ln[i] = 0; m_fr[i] = 0;
      end
    end
  endtask

  task automatic model_pos(input int i, output int x, output int y,
                           output int hs, output int vs, output int de);
    int hsta, vsta;
    hsta = -(hfp[i] + hsw[i] + hbp[i]);
    vsta = -(vfp[i] + vsw[i] + vbp[i]);
    x  = hsta + (m_k[i] % ht[i]);
    y  = vsta + (m_k[i] / ht[i]);
    hs = (x >= hsta + hfp[i] && x <= hsta + hfp[i] + hsw[i] - 1) ? pol[i] : 1 - pol[i];
    vs = (y >= vsta + vfp[i] && y <= vsta + vfp[i] + vsw[i] - 1) ? pol[i] : 1 - pol[i];
    de = (x >= 0 && y >= 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    int x, y, hs, vs, de;
    model_pos(0, x, y, hs, vs, de);
    chk("s_x", int'(s_x), x);
    chk("s_y", int'(s_y), y);
    chk("s_hsync", int'(s_hs), hs);
    chk("s_vsync", int'(s_vs), vs);
    chk("s_de", int'(s_de), de);
    chk("s_line", int'(s_ln), int'(m_ln[0]));
    chk("s_frame", int'(s_fr), int'(m_fr[0]));
    chk("s_frame_cnt", int'(s_fc), m_fc[0]);
    model_pos(1, x, y, hs, vs, de);
    chk("f_x", int'(f_x), x);
    chk("f_y", int'(f_y), y);
    chk("f_hsync", int'(f_hs), hs);
    chk("f_vsync", int'(f_vs), vs);
    chk("f_de", int'(f_de), de);
    chk("f_line", int'(f_ln), int'(m_ln[1]));
    chk("f_frame", int'(f_fr), int'(m_fr[1]));
    chk("f_frame_cnt", int'(f_fc), m_fc[1]);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input bit r, input bit e);
    rst_pix_n = r;
    i_en      = e;
    @(posedge clk_pix);
    #1;
    model_step(r, e);
    compare_all();
    @(negedge clk_pix);
  endtask

  // Run enabled until the reduced raster reaches advance index kt; a missed target is a failure.
  task automatic run_to(input int kt, input string tag);
    int n;
    n = 0;
    while (!(m_st[0] && m_k[0] == kt) && n < 3 * tot[0]) begin
      step(1, 1);
      n++;
    end
    chk(tag, m_k[0], kt);
  endtask

  initial begin
    int fc0, k_mid;
    hres = '{S_HRES, 1280}; vres = '{S_VRES, 720};
    hfp  = '{S_HFP, 110};   hsw  = '{S_HSYNC, 40}; hbp = '{S_HBP, 220};
    vfp  = '{S_VFP, 5};     vsw  = '{S_VSYNC, 5};  vbp = '{S_VBP, 20};
    pol  = '{0, 1};
    for (int i = 0; i < 2; i++) begin
      ht[i]  = hfp[i] + hsw[i] + hbp[i] + hres[i];
      vt[i]  = vfp[i] + vsw[i] + vbp[i] + vres[i];
      tot[i] = ht[i] * vt[i];
    end
    @(negedge clk_pix);

    // Reset held with enable high.
    repeat (5) step(0, 1);
    chk("rst_full_x", int'(f_x), -370);
    chk("rst_full_y", int'(f_y), -30);

    // First frame after release: strobes at the start position, then the first advance.
    step(1, 1);
    chk("first_frame_strobe", int'(f_fr), 1);
    chk("first_line_strobe", int'(f_ln), 1);
    chk("first_x", int'(f_x), -370);
    step(1, 1);
    chk("second_x", int'(f_x), -369);
    chk("second_frame_strobe", int'(f_fr), 0);

    // Several complete reduced frames back-to-back.
    repeat (3 * tot[0]) step(1, 1);

    // Random enable gaps.
    repeat (2000) step(1, $urandom_range(0, 3) != 0);

    // Freeze on the last pixel of the frame, then wrap.
    run_to(tot[0] - 1, "reach_last_pixel");
    fc0 = int'(s_fc);
    repeat (7) step(1, 0);
    chk("freeze_x", int'(s_x), S_HRES - 1);
    step(1, 1);
    chk("wrap_frame_cnt", int'(s_fc), (fc0 + 1) % 65536);
    chk("wrap_frame_strobe", int'(s_fr), 1);
    // Enable dropped on the cycle after a strobe: strobe must not persist.
    step(1, 0);
    chk("strobe_drop", int'(s_fr), 0);
    repeat (3) step(1, 0);
    repeat (tot[0] + 5) step(1, 1);

    // Mid-frame reset at the middle of the active area.
    k_mid = (S_VRES / 2 + S_VFP + S_VSYNC + S_VBP) * ht[0] + (S_HRES / 2 + S_HFP + S_HSYNC + S_HBP);
    run_to(k_mid, "reach_mid");
    step(0, 1);
    chk("midrst_frame_cnt", int'(s_fc), 0);
    chk("midrst_x", int'(s_x), -(S_HFP + S_HSYNC + S_HBP));
    step(1, 1);
    chk("restart_frame_strobe", int'(s_fr), 1);
    repeat (1500) step(1, $urandom_range(0, 4) != 0);

    // Long enabled run so the 720p instance crosses several full lines.
    repeat (3400) step(1, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
